// File: rtl/reaction_tester_multi.sv
// Multi-player reaction-time engine: random pre-stimulus delay, shared millisecond
// counter, foul detection, winner selection and per-player min/max/last/average statistics.
module reaction_tester_multi #(
    parameter int CLK_HZ    = 50_000_000,
    parameter int TICK_HZ   = 1000,
    parameter int N_PLAYERS = 2,
    parameter int MAX_COUNT = 999,
    parameter int MIN_DELAY = 2000,
    parameter int MAX_DELAY = 6000,
    localparam int W  = $clog2(MAX_COUNT + 1),
    localparam int SW = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1
) (
    input  logic                   clk_50M,
    input  logic                   clear_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic [N_PLAYERS-1:0]   stop,
    input  logic [SW-1:0]          stat_sel,
    input  logic [1:0]             stat_kind,
    output logic                   led,
    output logic                   busy,
    output logic [N_PLAYERS*W-1:0] times,
    output logic [N_PLAYERS-1:0]   foul,
    output logic                   done,
    output logic [SW-1:0]          winner,
    output logic                   winner_valid,
    output logic [W-1:0]           stat_value,
    output logic                   stat_valid
);

    localparam int DIV   = CLK_HZ / TICK_HZ;
    localparam int PW    = $clog2(DIV);
    localparam int RANGE = MAX_DELAY - MIN_DELAY;
    localparam int RW    = (RANGE > 0) ? $clog2(RANGE + 1) : 1;
    localparam int DW    = $clog2(MAX_DELAY + 1);
    localparam int SUMW  = W + 16;
    localparam int CW    = $clog2(SUMW + 1);

    typedef enum logic [2:0] {S_IDLE, S_ARM, S_WAIT, S_RUN, S_DONE} state_t;

    state_t                 r_state;
    logic                   r_led, r_busy, r_done, r_winner_valid;
    logic [N_PLAYERS*W-1:0] r_times;
    logic [N_PLAYERS-1:0]   r_foul, r_stopped;
    logic [SW-1:0]          r_winner;
    logic [PW-1:0]          r_presc;
    logic [W-1:0]           r_cnt;
    logic [DW-1:0]          r_ticks, r_delay;
    logic [15:0]            r_lfsr;

    logic [15:0]            r_trials [N_PLAYERS];
    logic [SUMW-1:0]        r_sum    [N_PLAYERS];
    logic [W-1:0]           r_min    [N_PLAYERS];
    logic [W-1:0]           r_max    [N_PLAYERS];
    logic [W-1:0]           r_last   [N_PLAYERS];

    logic [SUMW-1:0]        r_dq;
    logic [16:0]            r_rem;
    logic [15:0]            r_dvs;
    logic [CW-1:0]          r_div_cnt;
    logic                   r_div_busy;
    logic [SW-1:0]          r_sel_q;
    logic [1:0]             r_kind_q;
    logic [W-1:0]           r_stat_value;
    logic                   r_stat_valid;

    logic                   w_tick, w_sat, w_all_foul, w_run_end, w_done_entry;
    logic [RW-1:0]          w_r;
    logic [N_PLAYERS*W-1:0] w_times_nxt;
    logic [N_PLAYERS-1:0]   w_foul_nxt, w_stopped_nxt;
    logic                   w_win_found;
    logic [SW-1:0]          w_win_idx;
    logic [W-1:0]           w_win_time, w_t;
    logic [15:0]            w_trials_nxt [N_PLAYERS];
    logic [SUMW-1:0]        w_sum_nxt    [N_PLAYERS];
    logic [W-1:0]           w_min_nxt    [N_PLAYERS];
    logic [W-1:0]           w_max_nxt    [N_PLAYERS];
    logic [W-1:0]           w_last_nxt   [N_PLAYERS];
    logic                   w_div_load, w_q_bit, w_has_trials, w_stat_ok;
    logic [16:0]            w_rem_sh, w_rem_step;
    logic [W-1:0]           w_stat_val;

    assign w_tick       = (r_presc == PW'(DIV - 1));
    assign w_sat        = w_tick && (r_cnt == W'(MAX_COUNT - 1));
    assign w_r          = r_lfsr[RW-1:0];
    assign w_all_foul   = &w_foul_nxt;
    assign w_run_end    = w_sat || (&(w_stopped_nxt | r_foul));
    assign w_done_entry = !abort && (((r_state == S_WAIT) && w_all_foul) ||
                                     ((r_state == S_RUN) && w_run_end));

    // Next-cycle view of fouls and captures; the tick that hits the ceiling captures MAX_COUNT.
    always_comb begin
        w_times_nxt   = r_times;
        w_foul_nxt    = r_foul;
        w_stopped_nxt = r_stopped;
        if (r_state == S_WAIT) begin
            w_foul_nxt = r_foul | stop;
        end else if (r_state == S_RUN) begin
            for (int i = 0; i < N_PLAYERS; i++) begin
                if (!r_foul[i] && !r_stopped[i] && (stop[i] || w_sat)) begin
                    w_times_nxt[i*W +: W] = w_sat ? W'(MAX_COUNT) : r_cnt;
                    w_stopped_nxt[i]      = 1'b1;
                end else begin
                    w_stopped_nxt[i] = r_stopped[i];
                end
            end
        end else begin
            w_foul_nxt = r_foul;
        end
    end

    // Winner: smallest non-fouled time, strict compare keeps the lowest index on ties.
    always_comb begin
        w_win_found = 1'b0;
        w_win_idx   = '0;
        w_win_time  = '0;
        for (int i = 0; i < N_PLAYERS; i++) begin
            if (!w_foul_nxt[i] && (!w_win_found || (w_times_nxt[i*W +: W] < w_win_time))) begin
                w_win_found = 1'b1;
                w_win_idx   = SW'(i);
                w_win_time  = w_times_nxt[i*W +: W];
            end else begin
                w_win_found = w_win_found;
            end
        end
    end

    // Statistics as they will stand after this cycle; only non-fouled players update at round end.
    always_comb begin
        w_t = '0;
        for (int i = 0; i < N_PLAYERS; i++) begin
            w_t             = w_times_nxt[i*W +: W];
            w_trials_nxt[i] = r_trials[i];
            w_sum_nxt[i]    = r_sum[i];
            w_min_nxt[i]    = r_min[i];
            w_max_nxt[i]    = r_max[i];
            w_last_nxt[i]   = r_last[i];
            if (w_done_entry && !w_foul_nxt[i]) begin
                w_last_nxt[i] = w_t;
                if (r_trials[i] != 16'hFFFF) begin
                    w_trials_nxt[i] = r_trials[i] + 16'd1;
                    w_sum_nxt[i]    = r_sum[i] + SUMW'(w_t);
                    w_min_nxt[i]    = (w_t < r_min[i]) ? w_t : r_min[i];
                    w_max_nxt[i]    = (w_t > r_max[i]) ? w_t : r_max[i];
                end else begin
                    w_trials_nxt[i] = r_trials[i];
                end
            end else begin
                w_last_nxt[i] = r_last[i];
            end
        end
    end

    // Free-running Fibonacci LFSR, taps 16,14,13,11.
    always_ff @(posedge clk_50M or negedge clear_n) begin
        if (!clear_n) begin
            r_lfsr <= 16'hACE1;
        end else begin
            r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
        end
    end

    // Round FSM with registered outputs.
    always_ff @(posedge clk_50M or negedge clear_n) begin
        if (!clear_n) begin
            r_state        <= S_IDLE;
            r_led          <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_times        <= '0;
            r_foul         <= '0;
            r_stopped      <= '0;
            r_winner       <= '0;
            r_winner_valid <= 1'b0;
            r_presc        <= '0;
            r_cnt          <= '0;
            r_ticks        <= '0;
            r_delay        <= '0;
        end else begin
            r_done <= 1'b0;
            if (abort) begin
                r_state <= S_IDLE;
                r_led   <= 1'b0;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE, S_DONE: begin
                        if (start) begin
                            r_state        <= S_ARM;
                            r_busy         <= 1'b1;
                            r_times        <= '0;
                            r_foul         <= '0;
                            r_stopped      <= '0;
                            r_winner_valid <= 1'b0;
                            r_cnt          <= '0;
                            r_presc        <= '0;
                        end
                    end
                    S_ARM: begin
                        if (w_r <= RW'(RANGE)) begin
                            r_delay <= DW'(MIN_DELAY) + DW'(w_r);
                            r_ticks <= '0;
                            r_presc <= '0;
                            r_state <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        r_foul  <= w_foul_nxt;
                        r_presc <= w_tick ? '0 : r_presc + PW'(1);
                        if (w_done_entry) begin
                            r_state        <= S_DONE;
                            r_busy         <= 1'b0;
                            r_done         <= 1'b1;
                            r_winner       <= w_win_idx;
                            r_winner_valid <= w_win_found;
                        end else if (w_tick) begin
                            if (r_ticks == r_delay - DW'(1)) begin
                                r_state <= S_RUN;
                                r_led   <= 1'b1;
                                r_cnt   <= '0;
                            end else begin
                                r_ticks <= r_ticks + DW'(1);
                            end
                        end
                    end
                    S_RUN: begin
                        r_times   <= w_times_nxt;
                        r_stopped <= w_stopped_nxt;
                        r_presc   <= w_tick ? '0 : r_presc + PW'(1);
                        if (w_tick && (r_cnt != W'(MAX_COUNT))) begin
                            r_cnt <= r_cnt + W'(1);
                        end
                        if (w_done_entry) begin
                            r_state        <= S_DONE;
                            r_led          <= 1'b0;
                            r_busy         <= 1'b0;
                            r_done         <= 1'b1;
                            r_winner       <= w_win_idx;
                            r_winner_valid <= w_win_found;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_led   <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Per-player statistics registers; min starts at all-ones so the first trial always wins.
    always_ff @(posedge clk_50M or negedge clear_n) begin
        if (!clear_n) begin
            for (int i = 0; i < N_PLAYERS; i++) begin
                r_trials[i] <= '0;
                r_sum[i]    <= '0;
                r_min[i]    <= '1;
                r_max[i]    <= '0;
                r_last[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < N_PLAYERS; i++) begin
                r_trials[i] <= w_trials_nxt[i];
                r_sum[i]    <= w_sum_nxt[i];
                r_min[i]    <= w_min_nxt[i];
                r_max[i]    <= w_max_nxt[i];
                r_last[i]   <= w_last_nxt[i];
            end
        end
    end

    assign w_div_load = w_done_entry ||
                        ((stat_kind == 2'b11) && ((stat_sel != r_sel_q) || (stat_kind != r_kind_q)));
    assign w_rem_sh   = {r_rem[15:0], r_dq[SUMW-1]};
    assign w_q_bit    = (w_rem_sh >= {1'b0, r_dvs});
    assign w_rem_step = w_q_bit ? (w_rem_sh - {1'b0, r_dvs}) : w_rem_sh;

    // Restoring divider: one quotient bit per cycle, quotient shifts into r_dq.
    always_ff @(posedge clk_50M or negedge clear_n) begin
        if (!clear_n) begin
            r_dq       <= '0;
            r_rem      <= '0;
            r_dvs      <= '0;
            r_div_cnt  <= '0;
            r_div_busy <= 1'b0;
            r_sel_q    <= '0;
            r_kind_q   <= '0;
        end else begin
            r_sel_q  <= stat_sel;
            r_kind_q <= stat_kind;
            if (w_div_load) begin
                r_dq       <= w_sum_nxt[stat_sel];
                r_dvs      <= w_trials_nxt[stat_sel];
                r_rem      <= '0;
                r_div_cnt  <= CW'(SUMW);
                r_div_busy <= 1'b1;
            end else if (r_div_busy) begin
                r_rem      <= w_rem_step;
                r_dq       <= {r_dq[SUMW-2:0], w_q_bit};
                r_div_cnt  <= r_div_cnt - CW'(1);
                r_div_busy <= (r_div_cnt != CW'(1));
            end
        end
    end

    // Statistic selection; the average is withheld while the divider is working.
    always_comb begin
        w_stat_val   = '0;
        w_stat_ok    = 1'b0;
        w_has_trials = (r_trials[stat_sel] != 16'd0);
        case (stat_kind)
            2'b00: begin
                w_stat_val = r_last[stat_sel];
                w_stat_ok  = w_has_trials;
            end
            2'b01: begin
                w_stat_val = r_min[stat_sel];
                w_stat_ok  = w_has_trials;
            end
            2'b10: begin
                w_stat_val = r_max[stat_sel];
                w_stat_ok  = w_has_trials;
            end
            2'b11: begin
                w_stat_val = r_dq[W-1:0];
                w_stat_ok  = w_has_trials && !r_div_busy && !w_div_load;
            end
            default: begin
                w_stat_val = '0;
                w_stat_ok  = 1'b0;
            end
        endcase
    end

    // Registered statistic output, zeroed when not meaningful.
    always_ff @(posedge clk_50M or negedge clear_n) begin
        if (!clear_n) begin
            r_stat_value <= '0;
            r_stat_valid <= 1'b0;
        end else begin
            r_stat_value <= w_stat_ok ? w_stat_val : '0;
            r_stat_valid <= w_stat_ok;
        end
    end

    assign led          = r_led;
    assign busy         = r_busy;
    assign times        = r_times;
    assign foul         = r_foul;
    assign done         = r_done;
    assign winner       = r_winner;
    assign winner_valid = r_winner_valid;
    assign stat_value   = r_stat_value;
    assign stat_valid   = r_stat_valid;

endmodule

// File: doc/reaction_tester_multi.md
# reaction_tester_multi

Parametrised multi-player reaction-time engine for the reaction-tester design. It draws a random pre-stimulus delay, lights the stimulus LED, and times up to `N_PLAYERS` stop buttons against one shared millisecond counter. It flags fouls, picks the winner, and keeps per-player min/max/average statistics across rounds. It sits between the conditioned button inputs and the display/scan logic. All numeric outputs are binary; BCD conversion is downstream.

## Interface
- `CLK_HZ`, 50_000_000, input clock frequency
- `TICK_HZ`, 1000, counter tick rate; `DIV = CLK_HZ/TICK_HZ` (integer, ≥2)
- `N_PLAYERS`, 2, number of stop inputs (1..8)
- `MAX_COUNT`, 999, counter ceiling in ticks; `W = clog2(MAX_COUNT+1)`
- `MIN_DELAY`, 2000, minimum stimulus delay in ticks
- `MAX_DELAY`, 6000, maximum stimulus delay in ticks (inclusive, ≥ MIN_DELAY)
- `clk_50M`  in  1  system clock
- `clear_n`  in  1  reset; one clock; asynchronous, active-low; clears everything including statistics
- `start`  in  1  one-cycle pulse, synchronous, debounced upstream
- `abort`  in  1  one-cycle pulse; return to IDLE, statistics kept
- `stop`  in  N_PLAYERS  one-cycle pulses, one per player
- `stat_sel`  in  max(1,clog2(N_PLAYERS))  player queried
- `stat_kind`  in  2  00 last, 01 min, 10 max, 11 average
- `led`  out  1  stimulus indicator
- `busy`  out  1  high in ARM, WAIT, RUN
- `times`  out  N_PLAYERS*W  captured time per player, player i at bits [i*W +: W]
- `foul`  out  N_PLAYERS  per-player foul flags for current/last round
- `done`  out  1  one-cycle pulse at round end
- `winner`  out  max(1,clog2(N_PLAYERS))  winning player index
- `winner_valid`  out  1  high in DONE when at least one non-foul time exists
- `stat_value`  out  W  selected statistic
- `stat_valid`  out  1  stat_value meaningful (player has ≥1 trial, divider idle)

## Operation
- **Reset values:** all outputs 0. State IDLE. Counters, LFSR seed 16'hACE1, and statistics cleared; min register set to all-ones internally.
- **IDLE/DONE:** `start` → ARM. Clears `times`, `foul`, `winner_valid`, counter and prescaler. `stop` is ignored.
- **ARM:** a free-running 16-bit Fibonacci LFSR (taps 16,14,13,11) is sampled each cycle.
  - Its low `clog2(MAX_DELAY-MIN_DELAY+1)` bits are r.
  - If r ≤ MAX_DELAY-MIN_DELAY, latch D = MIN_DELAY + r → WAIT.
  - Otherwise resample next cycle (rejection sampling).
- **WAIT:** the prescaler counts ticks.
  - A `stop[i]` sets `foul[i]`; `times[i]` stays 0.
  - If every player has fouled → DONE; `led` never lights.
  - After D ticks → RUN, with `led`=1, counter=0 and prescaler restarted.
- **RUN:** the counter increments every DIV cycles and saturates at MAX_COUNT.
  - A first `stop[i]` from a non-fouled, not-yet-stopped player captures the counter into `times[i]`. Repeats are ignored.
  - Round ends (→ DONE, `led`=0, `done` pulse) when every player has stopped or fouled, or the counter reaches MAX_COUNT.
  - At a timeout, unstopped players get `times[i]`=MAX_COUNT.
- **Winner:** the smallest `times` among non-fouled players. Ties go to the lowest index.
- **Statistics:** updated on DONE entry, per non-fouled player only.
  - Trials: 16-bit, saturating; at saturation, stop accumulating sum/min/max.
  - Sum: W+16 bits.
  - Min, max, and last are also tracked.
- **Average:** floor(sum/trials), computed by a sequential restoring divider.
- **abort:** from any state → IDLE next cycle. `led`=0, no `done`, statistics untouched.
- `start` outside IDLE/DONE is ignored.

## Timing
- `stop[i]` sampled in cycle t → `times[i]` holds the counter value of cycle t, visible at t+1.
- LED rises exactly D·DIV cycles after WAIT entry. The counter first reads 1 exactly DIV cycles after LED rise.
- `done`, `winner`, `winner_valid` and statistics are all valid in the first DONE cycle.
- Average latency:
  - The divider starts on DONE entry, or on any change of `stat_sel`/`stat_kind` while `stat_kind`=11.
  - `stat_valid` is low for W+17 cycles, then high with the quotient.
- Kinds 00/01/10 have a 1-cycle registered latency.
- `stat_valid`=0 while the selected player has zero trials.
- Simultaneous events:
  - `stop[i]` in the same cycle as the last WAIT tick → foul.
  - `stop[i]` in the same cycle the counter reaches MAX_COUNT → capture MAX_COUNT.
  - `abort` with `start` → abort wins.
- `clear_n` asserted mid-round: everything returns to reset values immediately; `led` drops asynchronously.

## Test plan
Bench uses CLK_HZ=4000, TICK_HZ=1000 (DIV=4), MAX_COUNT=999, MIN_DELAY=2, MAX_DELAY=6, N_PLAYERS=2.
- Reset, `start` → the drawn delay D is in 2..6. LED rises D·4 cycles after WAIT entry.
- LED up. `stop[0]` at 600 cycles after LED, `stop[1]` at 1200 → times 150/300, `winner`=0, `winner_valid`=1, one `done` pulse.
- `stop[1]` during WAIT, `stop[0]` 400 cycles after LED → `foul`=2'b10, times[0]=100, `winner`=0. Both players fouling → DONE with LED never lit and `winner_valid`=0.
- No stops → counter saturates at 999, both times=999. `done` occurs 3996 cycles after LED.
- Three rounds with player 0 times 120, 200, 250 → min 120, max 250, avg 190. For avg, `stat_valid` is low for W+17 = 27 cycles.
- `abort`, then `clear_n` pulsed in RUN → `abort` keeps the avg at 190 and gives no `done`. `clear_n` zeros `led`, `busy` and `stat_valid` immediately.
